// File: rtl/word_serializer_if.sv
// Handshake and serial-output bundle between a word source, the serializer and its bit consumer.
// Latency: none (wires only).
// Backpressure: in_ready from the serializer gates in_valid; the serial side has no backpressure.
//
// Signals:
//   in_data     parallel word from the source, sampled on accept
//   in_valid    source has a word on in_data
//   in_ready    serializer can take a word this cycle
//   out_bit     serial data bit
//   out_valid   out_bit carries a live data bit
//   frame_start first bit of a word
//   busy        serializer is shifting or holds a buffered word
interface word_serializer_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic             out_bit;
    logic             out_valid;
    logic             frame_start;
    logic             busy;

    // Source / observer side (testbench or upstream logic).
    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        input  out_bit,
        input  out_valid,
        input  frame_start,
        input  busy
    );

    // Serializer side.
    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        output out_bit,
        output out_valid,
        output frame_start,
        output busy
    );
endinterface

// File: rtl/word_serializer.sv
// Parallel-to-serial converter: one WIDTH-bit word in, WIDTH serial bits out, one per cycle.
// Latency: a word accepted on edge N drives its first bit during cycle N+1; words stream gap-free.
// Backpressure: one word of buffering behind the shifter; in_ready drops while that buffer is full.
//
// Ports:
//   clk    rising-edge clock for all state
//   reset  asynchronous active-low reset, clears all state immediately
//   bus    word_serializer_if.slave (in_data/in_valid/in_ready, out_bit/out_valid/frame_start, busy)
//
// Parameters:
//   WIDTH      bits per word, legal range 2..32
//   MSB_FIRST  1: bit WIDTH-1 leaves first; 0: bit 0 leaves first
module word_serializer #(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 1
) (
    input  logic              clk,
    input  logic              reset,
    word_serializer_if.slave  bus
);

    localparam int CW      = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam int OUT_IDX = (MSB_FIRST != 0) ? WIDTH - 1 : 0;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    state_e           state_q,    state_d;
    logic [WIDTH-1:0] shreg_q,    shreg_d;
    logic [WIDTH-1:0] buf_q,      buf_d;
    logic             buf_full_q, buf_full_d;
    logic [CW-1:0]    cnt_q,      cnt_d;
    // Low throughout reset and set by the first edge after release, so the
    // block never advertises readiness while it is being held in reset.
    logic             rdy_en_q,   rdy_en_d;

    logic             accept;
    logic             last_bit;
    logic             in_ready_int;
    logic [WIDTH-1:0] shreg_shifted;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            shreg_q    <= '0;
            buf_q      <= '0;
            buf_full_q <= 1'b0;
            cnt_q      <= '0;
            rdy_en_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            buf_q      <= buf_d;
            buf_full_q <= buf_full_d;
            cnt_q      <= cnt_d;
            rdy_en_q   <= rdy_en_d;
        end
    end

    // ------------------------------------------------------------------
    // Handshake decode (registered state plus in_valid only)
    // ------------------------------------------------------------------
    // While shifting, the only free slot is the hold buffer.
    assign in_ready_int = rdy_en_q && ((state_q == IDLE) || !buf_full_q);
    assign accept       = bus.in_valid && in_ready_int;
    assign last_bit     = (cnt_q == CW'(WIDTH - 1));

    // Move the shifter one position toward the output end; a zero fills the
    // vacated position so a finished word leaves no stale bits behind.
    generate
        if (MSB_FIRST != 0) begin : g_msb_first
            assign shreg_shifted = {shreg_q[WIDTH-2:0], 1'b0};
        end else begin : g_lsb_first
            assign shreg_shifted = {1'b0, shreg_q[WIDTH-1:1]};
        end
    endgenerate

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        buf_d      = buf_q;
        buf_full_d = buf_full_q;
        cnt_d      = cnt_q;
        rdy_en_d   = 1'b1;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    shreg_d = bus.in_data;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end

            SHIFT: begin
                if (!last_bit) begin
                    shreg_d = shreg_shifted;
                    cnt_d   = cnt_q + CW'(1);
                    if (accept) begin
                        buf_d      = bus.in_data;
                        buf_full_d = 1'b1;
                    end
                end else if (buf_full_q) begin
                    // in_ready is low here, so no accept can collide with the reload.
                    shreg_d    = buf_q;
                    buf_full_d = 1'b0;
                    cnt_d      = '0;
                end else if (accept) begin
                    // Buffer empty on the last bit: load the new word straight
                    // into the shifter so the stream keeps going without a gap.
                    shreg_d = bus.in_data;
                    cnt_d   = '0;
                end else begin
                    shreg_d = '0;
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs: decoded only from registered state
    // ------------------------------------------------------------------
    assign bus.in_ready    = in_ready_int;
    assign bus.out_valid   = (state_q == SHIFT);
    assign bus.out_bit     = (state_q == SHIFT) ? shreg_q[OUT_IDX] : 1'b0;
    assign bus.frame_start = (state_q == SHIFT) && (cnt_q == '0);
    assign bus.busy        = (state_q == SHIFT) || buf_full_q;

endmodule

// File: tb/tb_word_serializer.sv
module tb_word_serializer;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    word_serializer_if #(.WIDTH(8)) ifc1 ();
    word_serializer_if #(.WIDTH(8)) ifc0 ();

    word_serializer #(.WIDTH(8), .MSB_FIRST(1)) u_msb (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc1)
    );

    word_serializer #(.WIDTH(8), .MSB_FIRST(0)) u_lsb (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc0)
    );

    typedef struct packed {
        logic b;
        logic first;
    } exp_t;

    exp_t q1[$];
    exp_t q0[$];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        assert (got === want) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, got, want);
    endtask

    // Scoreboard for the MSB-first instance: check outputs of this cycle,
    // then record an accept that will happen on the coming edge.
    always @(negedge clk) begin : mon1
        exp_t e;
        if (reset) begin
            chk("m1_out_valid", 32'(ifc1.out_valid), 32'(q1.size() != 0));
            if (ifc1.out_valid && q1.size() != 0) begin
                e = q1.pop_front();
                chk("m1_out_bit", 32'(ifc1.out_bit), 32'(e.b));
                chk("m1_frame_start", 32'(ifc1.frame_start), 32'(e.first));
            end else if (!ifc1.out_valid) begin
                chk("m1_idle_bit", 32'(ifc1.out_bit), 32'd0);
                chk("m1_idle_frame", 32'(ifc1.frame_start), 32'd0);
            end
            if (ifc1.in_valid && ifc1.in_ready) begin
                for (int i = 0; i < 8; i++) begin
                    e.b     = ifc1.in_data[7-i];
                    e.first = (i == 0);
                    q1.push_back(e);
                end
            end
        end
    end

    // Scoreboard for the LSB-first instance.
    always @(negedge clk) begin : mon0
        exp_t e;
        if (reset) begin
            chk("m0_out_valid", 32'(ifc0.out_valid), 32'(q0.size() != 0));
            if (ifc0.out_valid && q0.size() != 0) begin
                e = q0.pop_front();
                chk("m0_out_bit", 32'(ifc0.out_bit), 32'(e.b));
                chk("m0_frame_start", 32'(ifc0.frame_start), 32'(e.first));
            end
            if (ifc0.in_valid && ifc0.in_ready) begin
                for (int j = 0; j < 8; j++) begin
                    e.b     = ifc0.in_data[j];
                    e.first = (j == 0);
                    q0.push_back(e);
                end
            end
        end
    end

    // Offer a word on ifc1 until accepted (bounded); returns at edge+1 after the accept.
    task automatic send(input logic [7:0] w, output int waited);
        bit acc;
        acc    = 1'b0;
        waited = 0;
        ifc1.in_valid = 1'b1;
        ifc1.in_data  = w;
        for (int k = 0; k < 40 && !acc; k++) begin
            @(negedge clk);
            waited++;
            if (ifc1.in_ready) acc = 1'b1;
        end
        chk("send_accept", 32'(acc), 32'd1);
        if (acc) begin
            @(posedge clk);
            #1;
        end
        ifc1.in_valid = 1'b0;
    endtask

    // Wait (bounded) until the MSB-first scoreboard is empty; ends at edge+1.
    task automatic drain();
        for (int k = 0; k < 100 && q1.size() != 0; k++) begin
            @(posedge clk);
            #1;
        end
        chk("drain_q1", 32'(q1.size()), 32'd0);
        chk("drain_q0", 32'(q0.size()), 32'd0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int w;
        reset         = 1'b0;
        ifc1.in_valid = 1'b0;
        ifc1.in_data  = '0;
        ifc0.in_valid = 1'b0;
        ifc0.in_data  = '0;

        // Reset state before any clock edge
        #3;
        chk("rst_out_valid", 32'(ifc1.out_valid), 32'd0);
        chk("rst_out_bit", 32'(ifc1.out_bit), 32'd0);
        chk("rst_frame_start", 32'(ifc1.frame_start), 32'd0);
        chk("rst_busy", 32'(ifc1.busy), 32'd0);
        chk("rst_in_ready", 32'(ifc1.in_ready), 32'd0);
        chk("rst_in_ready_lsb", 32'(ifc0.in_ready), 32'd0);

        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("release_in_ready_pre_edge", 32'(ifc1.in_ready), 32'd0);
        @(posedge clk);
        #1;
        chk("release_in_ready", 32'(ifc1.in_ready), 32'd1);
        chk("release_in_ready_lsb", 32'(ifc0.in_ready), 32'd1);
        chk("release_busy", 32'(ifc1.busy), 32'd0);

        // Single word 8'hA9 into both bit orders
        ifc1.in_valid = 1'b1;
        ifc1.in_data  = 8'hA9;
        ifc0.in_valid = 1'b1;
        ifc0.in_data  = 8'hA9;
        @(posedge clk);
        #1;
        ifc1.in_valid = 1'b0;
        ifc0.in_valid = 1'b0;
        chk("a9_busy_c1", 32'(ifc1.busy), 32'd1);
        repeat (9) @(negedge clk);
        chk("a9_out_valid_c9", 32'(ifc1.out_valid), 32'd0);
        chk("a9_busy_c9", 32'(ifc1.busy), 32'd0);
        chk("a9_lsb_out_valid_c9", 32'(ifc0.out_valid), 32'd0);
        chk("a9_lsb_busy_c9", 32'(ifc0.busy), 32'd0);
        @(posedge clk);
        #1;

        // 8'h90 then 8'h09 into the hold buffer
        send(8'h90, w);
        send(8'h09, w);
        @(negedge clk);
        chk("buf_in_ready_c2", 32'(ifc1.in_ready), 32'd0);
        chk("buf_busy_c2", 32'(ifc1.busy), 32'd1);
        repeat (6) @(negedge clk);
        chk("buf_in_ready_c8", 32'(ifc1.in_ready), 32'd0);
        @(negedge clk);
        chk("buf_in_ready_c9", 32'(ifc1.in_ready), 32'd1);
        chk("buf_busy_c9", 32'(ifc1.busy), 32'd1);
        drain();

        // Bypass: second word first offered on the last-bit cycle
        send(8'h90, w);
        repeat (7) @(posedge clk);
        #1;
        send(8'h09, w);
        chk("bypass_wait", 32'(w), 32'd1);
        @(negedge clk);
        chk("bypass_in_ready_c9", 32'(ifc1.in_ready), 32'd1);
        chk("bypass_out_valid_c9", 32'(ifc1.out_valid), 32'd1);
        drain();

        // Held word while the buffer is full
        send(8'h90, w);
        send(8'h09, w);
        send(8'h55, w);
        chk("hold_wait_cycles", 32'(w), 32'd8);
        drain();

        // Asynchronous reset mid-word
        send(8'hFF, w);
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("arst_out_valid", 32'(ifc1.out_valid), 32'd0);
        chk("arst_out_bit", 32'(ifc1.out_bit), 32'd0);
        chk("arst_frame_start", 32'(ifc1.frame_start), 32'd0);
        chk("arst_busy", 32'(ifc1.busy), 32'd0);
        chk("arst_in_ready", 32'(ifc1.in_ready), 32'd0);
        q1.delete();
        q0.delete();
        @(posedge clk);
        #2;
        chk("arst_held_out_valid", 32'(ifc1.out_valid), 32'd0);
        reset = 1'b1;
        #1;
        chk("arst_release_in_ready_pre_edge", 32'(ifc1.in_ready), 32'd0);
        @(posedge clk);
        #1;
        chk("arst_release_in_ready", 32'(ifc1.in_ready), 32'd1);
        chk("arst_release_busy", 32'(ifc1.busy), 32'd0);
        repeat (10) @(posedge clk);
        #1;
        chk("arst_no_resume", 32'(ifc1.out_valid), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
